// File: rtl/seq_shifter.sv
// seq_shifter: multi-cycle shift unit that moves the operand one bit per clock.
// Operations are LSL, LSR, ASR and ROR. Requests arrive on a valid/ready
// handshake. The result and the last bit shifted out leave on a second
// valid/ready handshake. The unit holds one operation at a time.
module seq_shifter #(
    parameter  int WIDTH = 8,
    localparam int AMT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [AMT_W-1:0] in_amt,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_carry,
    output logic             busy
);

    localparam int SH_W = $clog2(WIDTH);

    localparam logic [1:0] MODE_LSL = 2'b00;
    localparam logic [1:0] MODE_LSR = 2'b01;
    localparam logic [1:0] MODE_ASR = 2'b10;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] data;
    logic [AMT_W-1:0] cnt;
    logic             carry;
    logic [1:0]       mode;
    logic             accept;

    // Rotation wraps modulo WIDTH. The other modes saturate at WIDTH,
    // because further steps could not change the result.
    function automatic logic [AMT_W-1:0] eff_amount(input logic [AMT_W-1:0] amt,
                                                    input logic [1:0]       m);
        if (m == 2'b11)
            return {1'b0, amt[SH_W-1:0]};
        else if (amt > AMT_W'(WIDTH))
            return AMT_W'(WIDTH);
        else
            return amt;
    endfunction

    // One-position shift. The result is packed as {bit shifted out, new data}.
    function automatic logic [WIDTH:0] shift_step(input logic [WIDTH-1:0] d,
                                                  input logic [1:0]       m);
        logic signed [WIDTH-1:0] sd;
        sd = d;
        case (m)
            MODE_LSL: return {d[WIDTH-1], d[WIDTH-2:0], 1'b0};
            MODE_LSR: return {d[0], 1'b0, d[WIDTH-1:1]};
            MODE_ASR: return {d[0], sd >>> 1};
            default:  return {d[0], d[0], d[WIDTH-1:1]};
        endcase
    endfunction

    assign accept    = in_valid && (state == IDLE);
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign out_data  = data;
    assign out_carry = carry;

    // State register; an asynchronous reset abandons any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next-state logic; SHIFT exits as soon as the counter reaches zero.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = SHIFT;
            SHIFT:   if (cnt == '0) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Operand, counter and carry. The data register is held in DONE, so the
    // result stays stable while the consumer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data  <= '0;
            cnt   <= '0;
            carry <= 1'b0;
            mode  <= MODE_LSL;
        end else if (accept) begin
            data  <= in_data;
            mode  <= in_mode;
            cnt   <= eff_amount(in_amt, in_mode);
            carry <= 1'b0;
        end else if (state == SHIFT && cnt != '0) begin
            {carry, data} <= shift_step(data, mode);
            cnt           <= cnt - AMT_W'(1);
        end
    end

endmodule

// File: tb/tb_seq_shifter.sv
// Directed and table-driven bench for seq_shifter. It drives a 4-bit and an
// 8-bit instance, with a short model-checked randomized run on the 8-bit one.
module tb_seq_shifter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic       in_valid4 = 1'b0, in_ready4, out_valid4, out_ready4 = 1'b0, out_carry4, busy4;
    logic [3:0] in_data4 = '0, out_data4;
    logic [2:0] in_amt4 = '0;
    logic [1:0] in_mode4 = '0;

    logic       in_valid8 = 1'b0, in_ready8, out_valid8, out_ready8 = 1'b0, out_carry8, busy8;
    logic [7:0] in_data8 = '0, out_data8;
    logic [3:0] in_amt8 = '0;
    logic [1:0] in_mode8 = '0;

    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    seq_shifter #(.WIDTH(4)) u4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
        .in_data(in_data4), .in_amt(in_amt4), .in_mode(in_mode4),
        .out_valid(out_valid4), .out_ready(out_ready4), .out_data(out_data4),
        .out_carry(out_carry4), .busy(busy4)
    );

    seq_shifter #(.WIDTH(8)) u8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
        .in_data(in_data8), .in_amt(in_amt8), .in_mode(in_mode8),
        .out_valid(out_valid8), .out_ready(out_ready8), .out_data(out_data8),
        .out_carry(out_carry8), .busy(busy8)
    );

    typedef struct {
        bit         w4;
        logic [7:0] d;
        logic [3:0] amt;
        logic [1:0] mode;
        logic [7:0] exp_d;
        logic       exp_c;
        int         exp_lat;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Independent closed-form reference for the 8-bit instance: {carry, data}.
    function automatic logic [8:0] model8(input logic [7:0] d, input logic [3:0] amt,
                                          input logic [1:0] m);
        int eff;
        logic [7:0] r;
        logic c;
        logic signed [7:0] sd;
        sd  = d;
        eff = (m == 2'b11) ? (int'(amt) % 8) : ((int'(amt) > 8) ? 8 : int'(amt));
        c   = 1'b0;
        case (m)
            2'b00: begin
                r = (eff >= 8) ? 8'h00 : (d << eff);
                if (eff != 0) c = d[8 - eff];
            end
            2'b01: begin
                r = d >> eff;
                if (eff != 0) c = d[eff - 1];
            end
            2'b10: begin
                r = sd >>> eff;
                if (eff != 0) c = d[eff - 1];
            end
            default: begin
                r = (d >> eff) | (d << (8 - eff));
                if (eff != 0) c = d[eff - 1];
            end
        endcase
        return {c, r};
    endfunction

    // Complete one request/result transaction on the chosen instance.
    // It measures the latency and checks that the result holds during stalls.
    task automatic run_op(input bit w4, input logic [7:0] d, input logic [3:0] amt,
                          input logic [1:0] m, input int stall,
                          output logic [7:0] res, output logic c, output int lat);
        bit got;
        int i;
        i = 0;
        while (!(w4 ? in_ready4 : in_ready8) && i < 50) begin
            @(posedge clk); #1;
            i++;
        end
        chk("in_ready_before_req", w4 ? in_ready4 : in_ready8, 1);
        if (w4) begin
            in_data4 = d[3:0]; in_amt4 = amt[2:0]; in_mode4 = m; in_valid4 = 1'b1;
        end else begin
            in_data8 = d; in_amt8 = amt; in_mode8 = m; in_valid8 = 1'b1;
        end
        @(posedge clk); #1;
        in_valid4 = 1'b0;
        in_valid8 = 1'b0;
        lat = 0;
        got = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            lat++;
            if ((w4 ? out_valid4 : out_valid8) == 1'b1) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) chk("out_valid_timeout", 0, 1);
        res = w4 ? {4'h0, out_data4} : out_data8;
        c   = w4 ? out_carry4 : out_carry8;
        for (int s = 0; s < stall; s++) begin
            @(posedge clk); #1;
            chk("stall_data_stable", w4 ? {4'h0, out_data4} : out_data8, res);
            chk("stall_valid_held", w4 ? out_valid4 : out_valid8, 1);
        end
        if (w4) out_ready4 = 1'b1; else out_ready8 = 1'b1;
        @(posedge clk); #1;
        out_ready4 = 1'b0;
        out_ready8 = 1'b0;
        chk("in_ready_after_take", w4 ? in_ready4 : in_ready8, 1);
    endtask

    initial begin
        vec_t vecs[$];
        logic [7:0] res;
        logic c;
        int lat;
        int seen;
        logic [8:0] mexp;
        logic [7:0] rd;
        logic [3:0] ra;
        logic [1:0] rm;
        int reff;

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready8", in_ready8, 1);
        chk("rst_out_valid8", out_valid8, 0);
        chk("rst_out_data8", out_data8, 0);
        chk("rst_out_carry8", out_carry8, 0);
        chk("rst_busy8", busy8, 0);
        chk("rst_in_ready4", in_ready4, 1);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;

        // Table entries: {w4, data, amt, mode, expected data, expected carry, expected latency}.
        vecs.push_back('{1, 8'h0A, 4'd1, 2'b10, 8'h0D, 1'b0, 2});
        vecs.push_back('{1, 8'h0A, 4'd1, 2'b01, 8'h05, 1'b0, 2});
        vecs.push_back('{1, 8'h0A, 4'd1, 2'b00, 8'h04, 1'b1, 2});
        vecs.push_back('{1, 8'h0A, 4'd1, 2'b11, 8'h05, 1'b0, 2});
        vecs.push_back('{1, 8'h0A, 4'd7, 2'b10, 8'h0F, 1'b1, 5});
        vecs.push_back('{1, 8'h0A, 4'd5, 2'b11, 8'h05, 1'b0, 2});
        vecs.push_back('{0, 8'h96, 4'd0, 2'b00, 8'h96, 1'b0, 1});
        vecs.push_back('{0, 8'h96, 4'd0, 2'b01, 8'h96, 1'b0, 1});
        vecs.push_back('{0, 8'h96, 4'd0, 2'b10, 8'h96, 1'b0, 1});
        vecs.push_back('{0, 8'h96, 4'd0, 2'b11, 8'h96, 1'b0, 1});
        vecs.push_back('{0, 8'h96, 4'd15, 2'b10, 8'hFF, 1'b1, 9});
        vecs.push_back('{0, 8'h96, 4'd12, 2'b00, 8'h00, 1'b0, 9});
        vecs.push_back('{0, 8'h96, 4'd12, 2'b11, 8'h69, 1'b0, 5});
        vecs.push_back('{0, 8'h96, 4'd3, 2'b01, 8'h12, 1'b1, 4});
        vecs.push_back('{0, 8'h96, 4'd2, 2'b10, 8'hE5, 1'b1, 3});
        vecs.push_back('{0, 8'h81, 4'd1, 2'b00, 8'h02, 1'b1, 2});
        vecs.push_back('{0, 8'h96, 4'd8, 2'b01, 8'h00, 1'b1, 9});

        foreach (vecs[i]) begin
            run_op(vecs[i].w4, vecs[i].d, vecs[i].amt, vecs[i].mode, 0, res, c, lat);
            chk($sformatf("vec%0d_data", i), res, vecs[i].exp_d);
            chk($sformatf("vec%0d_carry", i), c, vecs[i].exp_c);
            chk($sformatf("vec%0d_latency", i), lat, vecs[i].exp_lat);
        end

        // Backpressure, with in_valid asserted during SHIFT and DONE.
        in_data8 = 8'h96; in_amt8 = 4'd3; in_mode8 = 2'b01; in_valid8 = 1'b1;
        @(posedge clk); #1;
        in_data8 = 8'hFF; in_amt8 = 4'd0; in_mode8 = 2'b00;
        chk("bp_in_ready_shift", in_ready8, 0);
        chk("bp_busy_shift", busy8, 1);
        seen = 0;
        while (!out_valid8 && seen < 40) begin
            @(posedge clk); #1;
            seen++;
            chk("bp_in_ready_low", in_ready8, 0);
        end
        chk("bp_out_valid", out_valid8, 1);
        for (int s = 0; s < 5; s++) begin
            in_valid8 = ~in_valid8;
            @(posedge clk); #1;
            chk("bp_hold_data", out_data8, 8'h12);
            chk("bp_hold_carry", out_carry8, 1);
            chk("bp_hold_valid", out_valid8, 1);
            chk("bp_hold_in_ready", in_ready8, 0);
        end
        in_valid8 = 1'b0;
        out_ready8 = 1'b1;
        @(posedge clk); #1;
        out_ready8 = 1'b0;
        chk("bp_release_in_ready", in_ready8, 1);
        chk("bp_release_out_valid", out_valid8, 0);
        run_op(0, 8'h55, 4'd1, 2'b01, 0, res, c, lat);
        chk("bp_next_data", res, 8'h2A);
        chk("bp_next_carry", c, 1);
        chk("bp_next_latency", lat, 2);

        // Reset in the middle of a shift operation.
        in_data8 = 8'h96; in_amt8 = 4'd6; in_mode8 = 2'b00; in_valid8 = 1'b1;
        @(posedge clk); #1;
        in_valid8 = 1'b0;
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("mid_rst_in_ready", in_ready8, 1);
        chk("mid_rst_out_valid", out_valid8, 0);
        chk("mid_rst_out_data", out_data8, 0);
        chk("mid_rst_out_carry", out_carry8, 0);
        chk("mid_rst_busy", busy8, 0);
        in_data8 = 8'h01; in_amt8 = 4'd0; in_valid8 = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_no_accept_busy", busy8, 0);
        chk("rst_no_accept_data", out_data8, 0);
        in_valid8 = 1'b0;
        #2 rst_n = 1'b1;
        seen = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            if (out_valid8) seen++;
        end
        chk("mid_rst_no_out_valid", seen, 0);
        run_op(0, 8'h01, 4'd3, 2'b00, 0, res, c, lat);
        chk("post_rst_data", res, 8'h08);
        chk("post_rst_carry", c, 0);
        chk("post_rst_latency", lat, 4);

        // Randomized run against the closed-form model, with result stalls.
        for (int n = 0; n < 200; n++) begin
            rd = 8'($urandom);
            ra = 4'($urandom_range(0, 15));
            rm = 2'($urandom_range(0, 3));
            reff = (rm == 2'b11) ? (int'(ra) % 8) : ((int'(ra) > 8) ? 8 : int'(ra));
            mexp = model8(rd, ra, rm);
            run_op(0, rd, ra, rm, $urandom_range(0, 3), res, c, lat);
            chk("rand_data", res, mexp[7:0]);
            chk("rand_carry", c, mexp[8]);
            chk("rand_latency", lat, reff + 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
